fifo_write_arbiter: RTL and testbench

Round-robin, packet-aware arbiter that shares the single write port of a `fifo` instance among `num_req` requesters, such as the UART RX path, CPU MMIO store and debug injector. Each requester presents ready/valid beats tagged with `last`. Once granted, a requester holds the write port until its `last` beat is accepted, so packets never interleave in the FIFO. The block sits between the requesters and the FIFO write side (`wr_en`/`din`/`full`); the FIFO read side is untouched.

---
 rtl/fifo_write_arbiter_pkg.sv | 20 ++
 rtl/fifo_write_arbiter_rr_priority_select.sv | 31 +++
 rtl/fifo_write_arbiter.sv | 98 +++++++++
 tb/tb_fifo_write_arbiter.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_write_arbiter_pkg.sv
// Shared definitions for the FIFO write-port arbiter and its helpers.
package fifo_write_arbiter_pkg;

    // Arbiter FSM encoding.
    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_t;

    // Ceiling log2, used to size index ports from a requester count.
    function automatic int log2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < n) r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_write_arbiter_rr_priority_select.sv
// Combinational round-robin picker: first set request strictly after
// last_grant, wrapping around num_req.
import fifo_write_arbiter_pkg::*;

module rr_priority_select #(
    parameter int num_req  = 4,
    parameter int id_width = log2(num_req)
) (
    input  logic [num_req-1:0]  req,
    input  logic [id_width-1:0] last_grant,
    output logic [id_width-1:0] sel,
    output logic                any
);

    // Scan from the farthest candidate back to the nearest so the nearest
    // valid request after the pointer is the one left in sel.
    always_comb begin
        int idx;
        idx = 0;
        sel = '0;
        any = 1'b0;
        for (int i = num_req; i >= 1; i--) begin
            idx = (int'(last_grant) + i) % num_req;
            if (req[idx]) begin
                sel = id_width'(idx);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Packet-aware round-robin arbiter for the single FIFO write port.
// A granted requester keeps the port until its last beat is accepted.
import fifo_write_arbiter_pkg::*;

module fifo_write_arbiter #(
    parameter int data_width = 8,
    parameter int num_req    = 4,
    parameter int id_width   = log2(num_req)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [num_req-1:0]            req_valid,
    input  logic [num_req-1:0]            req_last,
    input  logic [num_req*data_width-1:0] req_data,
    output logic [num_req-1:0]            req_ready,
    output logic                          fifo_wr_en,
    output logic [data_width-1:0]         fifo_din,
    input  logic                          fifo_full,
    output logic                          grant_valid,
    output logic [id_width-1:0]           grant_id
);

    arb_state_t            state, state_nxt;
    logic [id_width-1:0]   grant_id_nxt;
    logic [id_width-1:0]   last_grant, last_grant_nxt;
    logic [id_width-1:0]   rr_sel;
    logic                  rr_any;
    logic                  accept;
    logic [data_width-1:0] beats [num_req];

    rr_priority_select #(
        .num_req  (num_req),
        .id_width (id_width)
    ) u_rr_select (
        .req        (req_valid),
        .last_grant (last_grant),
        .sel        (rr_sel),
        .any        (rr_any)
    );

    // Split the flat data bus into one beat per requester.
    always_comb begin
        for (int i = 0; i < num_req; i++) begin
            beats[i] = req_data[i*data_width +: data_width];
        end
    end

    // State, owner and round-robin pointer; pointer resets to the top
    // index so requester 0 wins the first arbitration.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            grant_id   <= '0;
            last_grant <= id_width'(num_req - 1);
        end else begin
            state      <= state_nxt;
            grant_id   <= grant_id_nxt;
            last_grant <= last_grant_nxt;
        end
    end

    // Next-state logic plus the combinational write-port outputs.
    always_comb begin
        state_nxt      = state;
        grant_id_nxt   = grant_id;
        last_grant_nxt = last_grant;
        accept         = 1'b0;
        req_ready      = '0;
        fifo_din       = '0;

        case (state)
            ST_IDLE: begin
                if (rr_any) begin
                    state_nxt      = ST_LOCKED;
                    grant_id_nxt   = rr_sel;
                    last_grant_nxt = rr_sel;
                end
            end
            ST_LOCKED: begin
                // A paused requester (valid low) keeps the grant.
                accept              = req_valid[grant_id] && !fifo_full;
                req_ready[grant_id] = accept;
                fifo_din            = beats[grant_id];
                if (accept && req_last[grant_id]) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        fifo_wr_en = accept;
    end

    assign grant_valid = (state == ST_LOCKED);

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter with a write log of the FIFO port.
`timescale 1ns/1ps
module tb_fifo_write_arbiter;

    localparam int DW = 8;
    localparam int NR = 4;
    localparam int IW = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [NR-1:0]    req_valid;
    logic [NR-1:0]    req_last;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]    req_ready;
    logic             fifo_wr_en;
    logic [DW-1:0]    fifo_din;
    logic             fifo_full;
    logic             grant_valid;
    logic [IW-1:0]    grant_id;

    int n_checks = 0;
    int n_errors = 0;
    logic [DW-1:0] wr_log [$];

    fifo_write_arbiter #(.data_width(DW), .num_req(NR)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_last    (req_last),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .fifo_wr_en  (fifo_wr_en),
        .fifo_din    (fifo_din),
        .fifo_full   (fifo_full),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    always #5 clk = ~clk;

    // Record every beat written into the FIFO, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst && fifo_wr_en) wr_log.push_back(fifo_din);
    end

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic at_mid();
        @(negedge clk);
    endtask

    task automatic set_req(input int i, input logic v, input logic l, input logic [DW-1:0] d);
        req_valid[i] = v;
        req_last[i]  = l;
        req_data[i*DW +: DW] = d;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic check_log(input string tag, input logic [DW-1:0] exp [$]);
        check({tag, "_len"}, wr_log.size(), exp.size());
        for (int k = 0; k < exp.size(); k++) begin
            check(tag, (k < wr_log.size()) ? int'(wr_log[k]) : 32'hFFFF, exp[k]);
        end
    endtask

    initial begin
        int order [5];
        int cnt1, cnt3, exp_id, diff;
        logic [DW-1:0] exp_q [$];

        rst = 1'b1; req_valid = '0; req_last = '0; req_data = '0; fifo_full = 1'b0;

        // Reset state
        step();
        at_mid();
        check("rst_grant_valid", grant_valid, 0);
        check("rst_wr_en", fifo_wr_en, 0);
        check("rst_ready", req_ready, 0);
        check("rst_din", fifo_din, 0);
        step();
        rst = 1'b0;

        // Reset release: all four valid, single-beat packets, order 0,1,2,3,0
        for (int i = 0; i < NR; i++) set_req(i, 1'b1, 1'b1, 8'(8'h10 + i));
        order = '{0, 1, 2, 3, 0};
        for (int k = 0; k < 5; k++) begin
            at_mid();
            check("rr_idle_wr_en", fifo_wr_en, 0);
            check("rr_idle_gv", grant_valid, 0);
            step();
            at_mid();
            check("rr_grant_id", grant_id, order[k]);
            check("rr_wr_en", fifo_wr_en, 1);
            check("rr_din", fifo_din, 8'h10 + order[k]);
            check("rr_ready", req_ready, 1 << order[k]);
            step();
        end
        req_valid = '0;

        // Packet integrity: req0 three beats while req2 waits
        do_reset();
        wr_log.delete();
        set_req(0, 1'b1, 1'b0, 8'hA1);
        set_req(2, 1'b1, 1'b1, 8'hB1);
        step();
        at_mid();
        check("pk_grant0", grant_id, 0);
        check("pk_ready_a1", req_ready, 4'b0001);
        step();
        set_req(0, 1'b1, 1'b0, 8'hA2);
        at_mid();
        check("pk_ready_a2", req_ready, 4'b0001);
        step();
        set_req(0, 1'b1, 1'b1, 8'hA3);
        at_mid();
        check("pk_ready_a3", req_ready, 4'b0001);
        step();
        req_valid[0] = 1'b0;
        at_mid();
        check("pk_bubble_gv", grant_valid, 0);
        step();
        at_mid();
        check("pk_grant2", grant_id, 2);
        check("pk_din_b1", fifo_din, 8'hB1);
        step();
        req_valid[2] = 1'b0;
        exp_q = '{8'hA1, 8'hA2, 8'hA3, 8'hB1};
        check_log("pk_log", exp_q);

        // Full stall mid-packet on req1
        wr_log.delete();
        set_req(1, 1'b1, 1'b0, 8'hC1);
        step();
        at_mid();
        check("fs_grant1", grant_id, 1);
        check("fs_c1_wr", fifo_wr_en, 1);
        step();
        set_req(1, 1'b1, 1'b0, 8'hC2);
        fifo_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            at_mid();
            check("fs_stall_wr", fifo_wr_en, 0);
            check("fs_stall_gid", grant_id, 1);
            check("fs_stall_gv", grant_valid, 1);
            check("fs_stall_ready", req_ready, 0);
            step();
        end
        fifo_full = 1'b0;
        at_mid();
        check("fs_resume_wr", fifo_wr_en, 1);
        check("fs_resume_din", fifo_din, 8'hC2);
        step();
        set_req(1, 1'b1, 1'b1, 8'hC3);
        at_mid();
        check("fs_c3_wr", fifo_wr_en, 1);
        step();
        req_valid[1] = 1'b0;
        exp_q = '{8'hC1, 8'hC2, 8'hC3};
        check_log("fs_log", exp_q);

        // Mid-packet pause on req3 while req0 waits
        wr_log.delete();
        set_req(3, 1'b1, 1'b0, 8'hD1);
        set_req(0, 1'b1, 1'b1, 8'hE1);
        step();
        at_mid();
        check("mp_grant3", grant_id, 3);
        check("mp_din_d1", fifo_din, 8'hD1);
        step();
        req_valid[3] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            at_mid();
            check("mp_pause_gv", grant_valid, 1);
            check("mp_pause_gid", grant_id, 3);
            check("mp_pause_wr", fifo_wr_en, 0);
            check("mp_pause_ready", req_ready, 0);
            step();
        end
        set_req(3, 1'b1, 1'b1, 8'hD2);
        at_mid();
        check("mp_resume_din", fifo_din, 8'hD2);
        check("mp_resume_wr", fifo_wr_en, 1);
        step();
        req_valid[3] = 1'b0;
        step();
        at_mid();
        check("mp_grant0", grant_id, 0);
        step();
        req_valid[0] = 1'b0;
        exp_q = '{8'hD1, 8'hD2, 8'hE1};
        check_log("mp_log", exp_q);

        // Reset after two of four beats from req2
        set_req(2, 1'b1, 1'b0, 8'hF1);
        step();
        at_mid();
        check("rm_grant2", grant_id, 2);
        step();
        set_req(2, 1'b1, 1'b0, 8'hF2);
        step();
        set_req(2, 1'b1, 1'b0, 8'hF3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        req_valid = 4'b0110;
        req_last  = 4'b0110;
        at_mid();
        check("rm_gv", grant_valid, 0);
        check("rm_last_grant", dut.last_grant, 3);
        step();
        at_mid();
        check("rm_lowest", grant_id, 1);
        step();
        req_valid = 4'b1010;
        req_last  = 4'b1010;

        // Fairness: req1 and req3 continuously valid; pointer sits at 1
        cnt1 = 0;
        cnt3 = 0;
        exp_id = 3;
        for (int p = 0; p < 20; p++) begin
            step();
            at_mid();
            check("fair_order", grant_id, exp_id);
            if (grant_id == 1) cnt1++;
            if (grant_id == 3) cnt3++;
            exp_id = (exp_id == 3) ? 1 : 3;
            step();
        end
        req_valid = '0;
        diff = (cnt1 > cnt3) ? cnt1 - cnt3 : cnt3 - cnt1;
        check("fair_balance", (diff <= 1) ? 1 : 0, 1);
        check("fair_total", cnt1 + cnt3, 20);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
